ddc_mix_cic: RTL and testbench

Digital down-converter front end that sits directly downstream of the NCO. It multiplies a real ADC sample stream by the NCO's cosine/sine outputs to form baseband I/Q, then decimates each channel with an N-stage CIC filter of fixed ratio R. The decimated I/Q words and a one-cycle `out_valid` strobe go to the following FIR/demodulator stage.

---
 rtl/ddc_pkg.sv | 27 ++
 rtl/cic_dec_chan.sv | 53 +++++
 rtl/ddc_mix_cic.sv | 78 +++++++
 tb/tb_ddc_mix_cic.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddc_pkg.sv
// Shared widths, helper functions and typedefs for the mixer + CIC down-converter.
package ddc_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'sd1 <<< r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // Accumulator width that guarantees modulo-correct CIC arithmetic.
  function automatic int cic_gw(input int dw, input int nw, input int n, input int r);
    return dw + nw + n * clog2(r);
  endfunction

  localparam int DDC_DW = 14;
  localparam int DDC_NW = 14;
  localparam int DDC_N  = 3;
  localparam int DDC_R  = 8;
  localparam int DDC_OW = 16;
  localparam int DDC_MW = DDC_DW + DDC_NW;
  localparam int DDC_GW = cic_gw(DDC_DW, DDC_NW, DDC_N, DDC_R);

  typedef logic signed [DDC_MW-1:0] prod_t;
  typedef logic signed [DDC_GW-1:0] acc_t;

endpackage

// File: rtl/cic_dec_chan.sv
// One CIC decimator channel: pipelined integrators, strobe-driven combs, shift and output register.
module cic_dec_chan
  import ddc_pkg::*;
#(
  parameter int MW = DDC_MW,
  parameter int GW = DDC_GW,
  parameter int N  = DDC_N,
  parameter int OW = DDC_OW,
  parameter int SH = DDC_GW - DDC_OW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clken,
  input  logic signed [MW-1:0] din,
  input  logic                 din_v,
  input  logic                 stb,
  output logic signed [OW-1:0] dout
);

  logic signed [GW-1:0] integ_r  [N];
  logic signed [GW-1:0] comb_d_r [N];
  logic signed [GW-1:0] comb_s   [N+1];

  // Comb chain sees the last integrator value before this cycle's update.
  always_comb begin
    comb_s[0] = integ_r[N-1];
    for (int k = 0; k < N; k++) begin
      comb_s[k+1] = comb_s[k] - comb_d_r[k];
    end
  end

  // Integrators: each stage adds the previous stage's registered value, wrapping mod 2^GW.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) integ_r[k] <= '0;
    end else if (clken & din_v) begin
      integ_r[0] <= integ_r[0] + GW'(din);
      for (int k = 1; k < N; k++) integ_r[k] <= integ_r[k] + integ_r[k-1];
    end
  end

  // Comb delays and output register update only on the decimation strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) comb_d_r[k] <= '0;
      dout <= '0;
    end else if (stb) begin
      for (int k = 0; k < N; k++) comb_d_r[k] <= comb_s[k];
      dout <= OW'(comb_s[N] >>> SH);
    end
  end

endmodule

// File: rtl/ddc_mix_cic.sv
// Real-to-I/Q mixer followed by twin CIC decimators sharing one frame counter.
module ddc_mix_cic
  import ddc_pkg::*;
#(
  parameter int DW = DDC_DW,
  parameter int NW = DDC_NW,
  parameter int N  = DDC_N,
  parameter int R  = DDC_R,
  parameter int OW = DDC_OW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clken,
  input  logic signed [DW-1:0] adc_i,
  input  logic                 adc_valid,
  input  logic signed [NW-1:0] nco_cos,
  input  logic signed [NW-1:0] nco_sin,
  input  logic                 nco_valid,
  output logic signed [OW-1:0] i_o,
  output logic signed [OW-1:0] q_o,
  output logic                 out_valid
);

  localparam int MW = DW + NW;
  localparam int GW = cic_gw(DW, NW, N, R);
  localparam int SH = GW - OW;
  localparam int CW = clog2(R);
  localparam logic [CW-1:0] DC_LAST = CW'(R - 1);

  logic signed [MW-1:0] mul_i_s;
  logic signed [MW-1:0] mul_q_s;
  logic signed [MW-1:0] pi_r;
  logic signed [MW-1:0] pq_r;
  logic                 p_v_r;
  logic [CW-1:0]        dc_r;
  logic                 stb_s;

  // Products are formed at MW bits so negating the most negative product cannot overflow.
  always_comb begin
    mul_i_s = MW'(adc_i) * MW'(nco_cos);
    mul_q_s = MW'(adc_i) * MW'(nco_sin);
    stb_s   = clken & p_v_r & (dc_r == DC_LAST);
  end

  // Mixer registers, product-valid flag and frame counter; all frozen while clken is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pi_r  <= '0;
      pq_r  <= '0;
      p_v_r <= 1'b0;
      dc_r  <= '0;
    end else if (clken) begin
      p_v_r <= adc_valid & nco_valid;
      if (adc_valid & nco_valid) begin
        pi_r <= mul_i_s;
        pq_r <= -mul_q_s;
      end
      if (p_v_r) dc_r <= (dc_r == DC_LAST) ? '0 : dc_r + CW'(1);
    end
  end

  // Strobe follows stb regardless of clken so it is always one cycle wide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_valid <= 1'b0;
    else          out_valid <= stb_s;
  end

  cic_dec_chan #(.MW(MW), .GW(GW), .N(N), .OW(OW), .SH(SH)) u_chan_i (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .din(pi_r), .din_v(p_v_r), .stb(stb_s), .dout(i_o)
  );

  cic_dec_chan #(.MW(MW), .GW(GW), .N(N), .OW(OW), .SH(SH)) u_chan_q (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .din(pq_r), .din_v(p_v_r), .stb(stb_s), .dout(q_o)
  );

endmodule

// File: tb/tb_ddc_mix_cic.sv
// Directed bench for ddc_mix_cic: DC vector table, gaps, mid-frame reset and a tone,
// all strobes also checked against a direct-form CIC reference.
module tb_ddc_mix_cic;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clken = 1'b0;
  logic adc_valid = 1'b0;
  logic nco_valid = 1'b0;
  logic signed [13:0] adc_i = 14'sd0;
  logic signed [13:0] nco_cos = 14'sd0;
  logic signed [13:0] nco_sin = 14'sd0;
  logic signed [15:0] i_o;
  logic signed [15:0] q_o;
  logic out_valid;

  always #5 clk = ~clk;

  ddc_mix_cic dut (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .adc_i(adc_i), .adc_valid(adc_valid),
    .nco_cos(nco_cos), .nco_sin(nco_sin), .nco_valid(nco_valid),
    .i_o(i_o), .q_o(q_o), .out_valid(out_valid)
  );

  typedef struct {
    int adc; int c; int s; int n; int exp_i; int exp_q;
  } vec_t;

  typedef struct {
    logic signed [15:0] i;
    logic signed [15:0] q;
    int cyc;
  } obs_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int strobe_m = 0;
  bit prev_ov = 1'b0;
  longint h [22];
  longint p_i_q[$];
  longint p_q_q[$];
  obs_t obs_q[$];
  logic signed [15:0] ref_i[$];
  logic signed [15:0] ref_q[$];
  vec_t vt [6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_tol(input string name, input longint act, input longint exp, input longint tol);
    n_cmp++;
    if (act < exp - tol || act > exp + tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Direct-form reference: CIC = three length-8 boxcars, decimated, taps end at sample 8m+4.
  function automatic logic signed [15:0] model_out(input bit quad, input int m);
    longint acc;
    int idx;
    acc = 0;
    for (int k = 0; k < 22; k++) begin
      idx = 8 * m + 4 - k;
      if (idx >= 0 && idx < p_i_q.size()) acc += h[k] * (quad ? p_q_q[idx] : p_i_q[idx]);
    end
    return 16'(acc >>> 21);
  endfunction

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Record the products of every accepted sample.
  always @(posedge clk) begin
    if (!reset_n) begin
      p_i_q.delete();
      p_q_q.delete();
    end else if (clken && adc_valid && nco_valid) begin
      p_i_q.push_back(longint'(adc_i) * longint'(nco_cos));
      p_q_q.push_back(-(longint'(adc_i) * longint'(nco_sin)));
    end
  end

  // Check each strobe against the reference and that it is a single cycle wide.
  always @(negedge clk) begin
    if (!reset_n) begin
      strobe_m = 0;
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        chk("model_i", i_o, model_out(1'b0, strobe_m));
        chk("model_q", q_o, model_out(1'b1, strobe_m));
        chk("ov_width", prev_ov, 0);
        obs_q.push_back('{i_o, q_o, cyc});
        strobe_m++;
      end
      prev_ov = out_valid;
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    clken = 1'b0;
    adc_valid = 1'b0;
    nco_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clken = 1'b1;
    adc_valid = 1'b0;
    nco_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_const(input int a, input int c, input int s, input int n);
    adc_i = 14'(a);
    nco_cos = 14'(c);
    nco_sin = 14'(s);
    clken = 1'b1;
    adc_valid = 1'b1;
    nco_valid = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    idle(4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acc_cnt;
    int guard;
    longint si;
    longint sq;
    real th;

    // Three-boxcar impulse response.
    for (int k = 0; k < 22; k++) begin
      h[k] = 0;
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++)
          if (k - a - b >= 0 && k - a - b < 8) h[k] += 1;
    end

    vt[0] = '{1000,  8191,  0,    200,  1999,  0};
    vt[1] = '{1000,  0,     8191, 200,  0,     -2000};
    vt[2] = '{-8192, -8192, 0,    4096, 16384, 0};
    vt[3] = '{8191,  8191,  0,    4096, 16380, 0};
    vt[4] = '{-1000, 8191,  0,    200,  -2000, 0};
    vt[5] = '{1000,  0,     -8191, 200, 0,     1999};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_i", i_o, 0);
    chk("rst_q", q_o, 0);
    chk("rst_ov", out_valid, 0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      base = obs_q.size();
      run_const(vt[v].adc, vt[v].c, vt[v].s, vt[v].n);
      chk($sformatf("v%0d_count", v), obs_q.size() - base, vt[v].n / 8);
      for (int k = base + 1; k < obs_q.size(); k++)
        chk($sformatf("v%0d_spacing", v), obs_q[k].cyc - obs_q[k-1].cyc, 8);
      for (int k = base + 4; k < obs_q.size(); k++) begin
        chk($sformatf("v%0d_i", v), obs_q[k].i, vt[v].exp_i);
        chk($sformatf("v%0d_q", v), obs_q[k].q, vt[v].exp_q);
      end
      if (v == 0)
        for (int k = base; k < obs_q.size(); k++) begin
          ref_i.push_back(obs_q[k].i);
          ref_q.push_back(obs_q[k].q);
        end
    end

    // Random dropouts must reproduce the gap-free sequence exactly.
    do_reset();
    base = obs_q.size();
    adc_i = 14'sd1000;
    nco_cos = 14'sd8191;
    nco_sin = 14'sd0;
    acc_cnt = 0;
    guard = 0;
    while (acc_cnt < 200 && guard < 5000) begin
      clken = ($urandom_range(0, 3) != 0);
      adc_valid = ($urandom_range(0, 3) != 0);
      nco_valid = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      if (clken && adc_valid && nco_valid) acc_cnt++;
      guard++;
      #1;
    end
    chk("gap_accepts", acc_cnt, 200);
    idle(4);
    chk("gap_count", obs_q.size() - base, 25);
    for (int k = 0; k < 25 && base + k < obs_q.size(); k++) begin
      chk("gap_i", obs_q[base + k].i, ref_i[k]);
      chk("gap_q", obs_q[base + k].q, ref_q[k]);
    end

    // Reset five samples into a frame; the next strobe needs eight fresh accepts.
    do_reset();
    adc_i = 14'sd1000;
    nco_cos = 14'sd8191;
    nco_sin = 14'sd4000;
    clken = 1'b1;
    adc_valid = 1'b1;
    nco_valid = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    chk("pre_reset_i_nonzero", (i_o != 16'sd0), 1);
    reset_n = 1'b0;
    #2;
    chk("mid_rst_i", i_o, 0);
    chk("mid_rst_q", q_o, 0);
    chk("mid_rst_ov", out_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("first_ov_edge%0d", k), out_valid, (k == 9) ? 1 : 0);
    end
    #1;
    idle(4);

    // Tone at fs/64 mixed to DC: 4-strobe windows cancel the 2x image.
    do_reset();
    base = obs_q.size();
    clken = 1'b1;
    adc_valid = 1'b1;
    nco_valid = 1'b1;
    for (int n = 0; n < 1024; n++) begin
      th = 2.0 * 3.14159265358979 * n / 64.0;
      adc_i = 14'(rnd(4000.0 * $cos(th)));
      nco_cos = 14'(rnd(8191.0 * $cos(th)));
      nco_sin = 14'(rnd(8191.0 * $sin(th)));
      @(posedge clk);
      #1;
    end
    idle(4);
    chk("tone_count", obs_q.size() - base, 128);
    for (int w = base + 4; w + 3 < obs_q.size(); w += 4) begin
      si = 0;
      sq = 0;
      for (int j = 0; j < 4; j++) begin
        si += obs_q[w + j].i;
        sq += obs_q[w + j].q;
      end
      chk_tol("tone_i_sum4", si, 15998, 12);
      chk_tol("tone_q_sum4", sq, 0, 12);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
